hs_tx_queue: RTL and testbench

Transmit-side buffer that sits directly upstream of the CPU-side handshake stage. It accepts words from the CPU core into a small FIFO and drives each word out over the four-phase send/ack protocol used between CPU and peripheral. Each transfer follows the sequence send↑, ack↑, send↓, ack↓. The peripheral's ack is asynchronous, so it passes through a 2-flop synchronizer before the state machine uses it.

---
 rtl/hs_pkg.sv | 11 +
 rtl/hs_fifo.sv | 55 +++++
 rtl/hs_tx_queue.sv | 76 +++++++
 tb/tb_hs_tx_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and default sizing for the CPU/peripheral send/ack handshake stages.
package hs_pkg;
    localparam int HS_DATA_W = 2;
    localparam int HS_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;
endpackage

// File: rtl/hs_fifo.sv
// Circular word buffer with separate occupancy count; a push into a full buffer
// is accepted only when a pop frees a slot in the same cycle.
module hs_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              pop_ok, accept;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && !empty;
    assign accept = push && (!full || pop_ok);
    assign head   = mem[rd_ptr];

    // Storage is not reset; reset only clears pointers and count.
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && full && !pop_ok;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/hs_tx_queue.sv
// Transmit queue: buffers CPU words and sends each over a four-phase send/ack
// handshake, with the asynchronous ack brought in through a 2-flop synchronizer.
module hs_tx_queue
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = HS_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   send,
    output logic [DATA_W-1:0]      dadoT,
    input  logic                   ack,
    output logic                   done
);
    state_t            state;
    logic [1:0]        sync_pipe;
    logic              ack_s, pop;
    logic [DATA_W-1:0] head;

    assign ack_s = sync_pipe[1];
    assign pop   = (state == IDLE) && !empty && !ack_s;

    hs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], ack};
    end

    // A high ack_s in IDLE is stale; wait for it to drop before starting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            send  <= 1'b0;
            dadoT <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    dadoT <= head;
                    send  <= 1'b1;
                    state <= REQ;
                end
                REQ: if (ack_s) begin
                    send  <= 1'b0;
                    state <= REL;
                end
                REL: if (!ack_s) begin
                    dadoT <= '0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_tx_queue.sv
// Directed bench for hs_tx_queue: handshake timing, overflow, full+pop, stale ack, async reset.
module tb_hs_tx_queue;
    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       full, empty, ovf, send, done;
    logic [2:0] count;
    logic [1:0] dadoT;
    logic       ack;

    logic       per_en, force_ack, model_ack, send_d, mon_send_prev;
    int         total = 0;
    int         bad   = 0;
    int         done_cnt = 0;
    logic [1:0] obs [$];

    always #5 clock = ~clock;

    assign ack = per_en ? model_ack : force_ack;

    hs_tx_queue dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .send    (send),
        .dadoT   (dadoT),
        .ack     (ack),
        .done    (done)
    );

    // Peripheral: ack follows send one cycle late, changing between clock edges.
    initial begin model_ack = 1'b0; send_d = 1'b0; mon_send_prev = 1'b0; end
    always @(negedge clock) begin
        model_ack <= send_d;
        send_d    <= send;
    end

    always @(negedge clock) begin
        if (done) done_cnt <= done_cnt + 1;
        if (send && !mon_send_prev) obs.push_back(dadoT);
        mon_send_prev <= send;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin tick(); n++; end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL %s timeout: done_cnt=%0d want %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; per_en = 1'b0; force_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++; if (send !== 1'b0)  begin bad++; $display("FAIL rst_send got=%b want=0", send); end
        total++; if (dadoT !== 2'b00) begin bad++; $display("FAIL rst_dadoT got=%b want=00", dadoT); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0)  begin bad++; $display("FAIL rst_full got=%b want=0", full); end
    endtask

    task automatic test_single();
        int d0, n;
        d0 = done_cnt;
        per_en = 1'b1;
        push_word(2'b10);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b want=0", empty); end
        tick();
        total++; if (send !== 1'b1 || dadoT !== 2'b10) begin
            bad++; $display("FAIL single_start send=%b dadoT=%b want 1/10", send, dadoT); end
        n = 0;
        while (ack !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_ack timeout"); end
        // first sample after edge E: send still high, falls after E+2
        total++; if (send !== 1'b1) begin bad++; $display("FAIL single_send_E got=%b want=1", send); end
        tick();
        total++; if (send !== 1'b1) begin bad++; $display("FAIL single_send_E1 got=%b want=1", send); end
        tick();
        total++; if (send !== 1'b0 || dadoT !== 2'b10) begin
            bad++; $display("FAIL single_send_E2 send=%b dadoT=%b want 0/10", send, dadoT); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (done !== 1'b1 || dadoT !== 2'b00) begin
            bad++; $display("FAIL single_done done=%b dadoT=%b want 1/00", done, dadoT); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_clear got=%b want=0", done); end
        repeat (5) tick();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt - d0); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d want=0", count); end
    endtask

    task automatic test_burst_ovf();
        int d0, o0;
        logic [1:0] exp [4];
        exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        per_en = 1'b0; force_ack = 1'b1;
        repeat (3) tick();
        d0 = done_cnt; o0 = obs.size();
        push_word(2'd1); push_word(2'd2); push_word(2'd3); push_word(2'd0);
        total++; if (count !== 3'd4 || full !== 1'b1) begin
            bad++; $display("FAIL burst_full count=%0d full=%b want 4/1", count, full); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL burst_ovf_early got=%b want=0", ovf); end
        push_word(2'd1);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL burst_ovf got=%b want=1", ovf); end
        tick();
        total++; if (ovf !== 1'b0 || count !== 3'd4) begin
            bad++; $display("FAIL burst_ovf_clear ovf=%b count=%0d want 0/4", ovf, count); end
        force_ack = 1'b0; per_en = 1'b1;
        wait_done(d0 + 4, "burst_drain");
        repeat (10) tick();
        total++; if (done_cnt - d0 !== 4) begin bad++; $display("FAIL burst_done_cnt got=%0d want=4", done_cnt - d0); end
        total++; if (obs.size() - o0 !== 4) begin bad++; $display("FAIL burst_words got=%0d want=4", obs.size() - o0); end
        for (int i = 0; i < 4; i++) begin
            if (o0 + i < obs.size()) begin
                total++; if (obs[o0+i] !== exp[i]) begin
                    bad++; $display("FAIL burst_word%0d got=%0d want=%0d", i, obs[o0+i], exp[i]); end
            end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL burst_empty got=%b want=1", empty); end
    endtask

    task automatic test_full_pop();
        int d0, o0, idx, n;
        logic [1:0] w [10];
        w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2};
        per_en = 1'b0; force_ack = 1'b1;
        repeat (3) tick();
        d0 = done_cnt; o0 = obs.size();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        force_ack = 1'b0;
        tick(); tick();
        total++; if (send !== 1'b0 || full !== 1'b1) begin
            bad++; $display("FAIL fp_pre send=%b full=%b want 0/1", send, full); end
        push_word(w[4]);
        total++; if (send !== 1'b1 || dadoT !== w[0]) begin
            bad++; $display("FAIL fp_start send=%b dadoT=%0d want 1/%0d", send, dadoT, w[0]); end
        total++; if (count !== 3'd4 || ovf !== 1'b0) begin
            bad++; $display("FAIL fp_same_cycle count=%0d ovf=%b want 4/0", count, ovf); end
        per_en = 1'b1;
        idx = 5; n = 0;
        while (idx < 10 && n < 300) begin
            if (!full) begin push_word(w[idx]); idx++; end
            else tick();
            n++;
        end
        wait_done(d0 + 10, "fp_drain");
        repeat (10) tick();
        total++; if (obs.size() - o0 !== 10) begin bad++; $display("FAIL fp_words got=%0d want=10", obs.size() - o0); end
        for (int i = 0; i < 10; i++) begin
            if (o0 + i < obs.size()) begin
                total++; if (obs[o0+i] !== w[i]) begin
                    bad++; $display("FAIL fp_word%0d got=%0d want=%0d", i, obs[o0+i], w[i]); end
            end
        end
    endtask

    task automatic test_stale_ack();
        int d0;
        logic seen;
        per_en = 1'b0; force_ack = 1'b1;
        repeat (3) tick();
        d0 = done_cnt;
        push_word(2'b11);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin if (send) seen = 1'b1; tick(); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL stale_hold send_seen=%b want=0", seen); end
        force_ack = 1'b0;
        tick(); tick();
        total++; if (send !== 1'b0) begin bad++; $display("FAIL stale_sync send=%b want=0", send); end
        tick();
        total++; if (send !== 1'b1 || dadoT !== 2'b11) begin
            bad++; $display("FAIL stale_start send=%b dadoT=%b want 1/11", send, dadoT); end
        per_en = 1'b1;
        wait_done(d0 + 1, "stale_done");
        repeat (5) tick();
    endtask

    task automatic test_async_reset();
        int d0;
        logic seen;
        per_en = 1'b0; force_ack = 1'b0;
        push_word(2'b01);
        tick();
        total++; if (send !== 1'b1) begin bad++; $display("FAIL ar_req send=%b want=1", send); end
        d0 = done_cnt;
        #3 reset = 1'b1;
        #1;
        total++; if (send !== 1'b0 || dadoT !== 2'b00) begin
            bad++; $display("FAIL ar_immediate send=%b dadoT=%b want 0/00", send, dadoT); end
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        total++; if (empty !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL ar_empty empty=%b count=%0d want 1/0", empty, count); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin if (send) seen = 1'b1; tick(); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ar_no_send send_seen=%b want=0", seen); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL ar_no_done got=%0d want=%0d", done_cnt, d0); end
        push_word(2'b10);
        tick();
        total++; if (send !== 1'b1 || dadoT !== 2'b10) begin
            bad++; $display("FAIL ar_restart send=%b dadoT=%b want 1/10", send, dadoT); end
        per_en = 1'b1;
        wait_done(d0 + 1, "ar_done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_ovf();
        test_full_pop();
        test_stale_ack();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
